// File: rtl/abs_cmd_ctrl_pkg.sv
// Shared debug-module definitions: command word layout, cmderr codes,
// FSM state encoding and the abstract-command legality check.
package abs_cmd_ctrl_pkg;

  localparam int DM_REG_WIDTH   = 32;
  localparam int CMD_REGNO_SIZE = 16;

  // Abstract command word, MSB first.
  typedef struct packed {
    logic [7:0]                cmdtype;   // [31:24]
    logic                      rsv23;     // [23]
    logic [2:0]                aarsize;   // [22:20]
    logic                      rsv19;     // [19]
    logic                      postexec;  // [18]
    logic                      transfer;  // [17]
    logic                      write;     // [16]
    logic [CMD_REGNO_SIZE-1:0] regno;     // [15:0]
  } cmd_t;

  localparam logic [2:0] CMDERR_NONE       = 3'd0;
  localparam logic [2:0] CMDERR_BUSY       = 3'd1;
  localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
  localparam logic [2:0] CMDERR_EXCEPT     = 3'd3;
  localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

  // Only 32-bit access-register commands are supported.
  localparam logic [2:0] AARSIZE_32 = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Error code for a freshly accepted command, first failing check wins.
  function automatic logic [2:0] check_cmd(input cmd_t c, input logic halted);
    if (c.cmdtype != 8'd0)                      return CMDERR_NOTSUP;
    if (c.postexec)                             return CMDERR_NOTSUP;
    if (c.transfer && c.aarsize != AARSIZE_32)  return CMDERR_NOTSUP;
    if (!halted)                                return CMDERR_HALTRESUME;
    return CMDERR_NONE;
  endfunction

endpackage

// File: rtl/abs_cmd_ctrl.sv
// Abstract-command controller: decodes access-register commands, runs one
// register access with a timeout, writes read data back to data0 and
// maintains the sticky cmderr field.
module abs_cmd_ctrl
  import abs_cmd_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                      sys_clk,
  input  logic                      sys_rstn,
  input  logic [DM_REG_WIDTH-1:0]   command,
  input  logic                      cmd_update,
  input  logic [DM_REG_WIDTH-1:0]   data0,
  input  logic [2:0]                cmderr_clr,
  input  logic                      core_halted,
  input  logic                      reg_ack,
  input  logic                      reg_err,
  input  logic [DM_REG_WIDTH-1:0]   reg_rdata,
  output logic                      reg_req,
  output logic                      wr1_rd0,
  output logic [CMD_REGNO_SIZE-1:0] regno,
  output logic [DM_REG_WIDTH-1:0]   write_data,
  output logic                      data0_we,
  output logic [DM_REG_WIDTH-1:0]   data0_wdata,
  output logic                      busy,
  output logic [2:0]                cmderr
);

  // Last wait-counter value before the access is abandoned.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  cmd_t       cmd;
  logic [2:0] chk;
  logic       unused_bits;

  assign cmd         = cmd_t'(command);
  assign chk         = check_cmd(cmd, core_halted);
  assign unused_bits = cmd.rsv23 ^ cmd.rsv19;

  // Command FSM; every output is registered. Later cmderr assignments
  // override the W1C clear so a new error beats a same-cycle clear.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      reg_req     <= 1'b0;
      data0_we    <= 1'b0;
      cmderr      <= CMDERR_NONE;
      wait_cnt    <= 8'd0;
      wr1_rd0     <= 1'b0;
      regno       <= '0;
      write_data  <= '0;
      data0_wdata <= '0;
    end else begin
      data0_we <= 1'b0;
      cmderr   <= cmderr & ~cmderr_clr;
      case (state)
        ST_IDLE: begin
          // A pending error locks out new commands until software clears it.
          if (cmd_update && cmderr == CMDERR_NONE) begin
            if (chk != CMDERR_NONE) begin
              cmderr <= chk;
            end else if (cmd.transfer) begin
              wr1_rd0    <= cmd.write;
              regno      <= cmd.regno;
              write_data <= data0;
              wait_cnt   <= 8'd0;
              reg_req    <= 1'b1;
              busy       <= 1'b1;
              state      <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (cmd_update && cmderr == CMDERR_NONE) cmderr <= CMDERR_BUSY;
          // An ack arriving in the timeout cycle still completes the access.
          if (reg_ack) begin
            reg_req <= 1'b0;
            state   <= ST_DONE;
            if (reg_err) begin
              cmderr <= CMDERR_EXCEPT;
            end else if (!wr1_rd0) begin
              data0_wdata <= reg_rdata;
              data0_we    <= 1'b1;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            cmderr  <= CMDERR_EXCEPT;
            reg_req <= 1'b0;
            state   <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          if (cmd_update && cmderr == CMDERR_NONE) cmderr <= CMDERR_BUSY;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          reg_req <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_abs_cmd_ctrl.sv
// Self-checking bench for abs_cmd_ctrl: directed scenarios plus randomized
// commands checked against a transaction-level reference model.
module tb_abs_cmd_ctrl;

  localparam int T = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rstn = 1'b0;
  logic [31:0] command = '0;
  logic        cmd_update = 1'b0;
  logic [31:0] data0 = '0;
  logic [2:0]  cmderr_clr = '0;
  logic        core_halted = 1'b0;
  logic        reg_ack = 1'b0;
  logic        reg_err = 1'b0;
  logic [31:0] reg_rdata = '0;
  logic        reg_req, wr1_rd0, data0_we, busy;
  logic [15:0] regno;
  logic [31:0] write_data, data0_wdata;
  logic [2:0]  cmderr;

  int checks = 0;
  int errors = 0;

  abs_cmd_ctrl #(.TIMEOUT_CYC(T)) dut (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn), .command(command),
    .cmd_update(cmd_update), .data0(data0), .cmderr_clr(cmderr_clr),
    .core_halted(core_halted), .reg_ack(reg_ack), .reg_err(reg_err),
    .reg_rdata(reg_rdata), .reg_req(reg_req), .wr1_rd0(wr1_rd0),
    .regno(regno), .write_data(write_data), .data0_we(data0_we),
    .data0_wdata(data0_wdata), .busy(busy), .cmderr(cmderr)
  );

  always #5 sys_clk = ~sys_clk;

  // Advance one clock; outputs are read and inputs driven 1 time unit later.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Reference rule set for command legality.
  function automatic logic [2:0] ref_err(input logic [31:0] c, input logic halted);
    if (c[31:24] != 8'd0)             return 3'd2;
    if (c[18])                        return 3'd2;
    if (c[17] && c[22:20] != 3'd2)    return 3'd2;
    if (!halted)                      return 3'd4;
    return 3'd0;
  endfunction

  // Pulse cmd_update for one cycle with the given command word.
  task automatic issue(input logic [31:0] c);
    command = c;
    cmd_update = 1'b1;
    tick();
    cmd_update = 1'b0;
  endtask

  task automatic clear_err();
    cmderr_clr = 3'b111;
    tick();
    cmderr_clr = 3'b000;
  endtask

  task automatic test_reset();
    sys_rstn = 1'b0;
    #2;
    checks++;
    if ({reg_req, busy, data0_we, cmderr, wr1_rd0, regno, write_data, data0_wdata} !== '0) begin
      errors++;
      $display("FAIL reset: req=%0b busy=%0b we=%0b cmderr=%0d regno=%h wd=%h rd=%h, all required 0",
               reg_req, busy, data0_we, cmderr, regno, write_data, data0_wdata);
    end
    tick();
    sys_rstn = 1'b1;
    tick();
  endtask

  task automatic test_read();
    core_halted = 1'b1;
    issue(32'h0022_0300);
    checks++;
    if ({reg_req, busy, wr1_rd0, regno} !== {1'b1, 1'b1, 1'b0, 16'h0300}) begin
      errors++;
      $display("FAIL read_req: req=%0b busy=%0b wr=%0b regno=%h, required 1 1 0 0300",
               reg_req, busy, wr1_rd0, regno);
    end
    tick();
    tick();
    reg_ack = 1'b1; reg_err = 1'b0; reg_rdata = 32'h1234_5678;
    tick();
    reg_ack = 1'b0;
    checks++;
    if ({data0_we, data0_wdata, cmderr, busy, reg_req} !== {1'b1, 32'h1234_5678, 3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL read_done: we=%0b data=%h cmderr=%0d busy=%0b req=%0b, required 1 12345678 0 1 0",
               data0_we, data0_wdata, cmderr, busy, reg_req);
    end
    tick();
    checks++;
    if ({data0_we, busy} !== 2'b00) begin
      errors++;
      $display("FAIL read_idle: we=%0b busy=%0b, required 0 0", data0_we, busy);
    end
  endtask

  task automatic test_write();
    core_halted = 1'b1;
    data0 = 32'hDEAD_BEEF;
    issue(32'h0023_1001);
    data0 = 32'h0;
    checks++;
    if ({reg_req, wr1_rd0, regno, write_data} !== {1'b1, 1'b1, 16'h1001, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL write_req: req=%0b wr=%0b regno=%h wd=%h, required 1 1 1001 deadbeef",
               reg_req, wr1_rd0, regno, write_data);
    end
    reg_ack = 1'b1; reg_rdata = 32'h5555_AAAA;
    tick();
    reg_ack = 1'b0;
    checks++;
    if ({data0_we, reg_req, busy} !== 3'b001) begin
      errors++;
      $display("FAIL write_done: we=%0b req=%0b busy=%0b, required 0 0 1", data0_we, reg_req, busy);
    end
    tick();
  endtask

  task automatic test_errors();
    logic [31:0] cmds [3];
    logic        halt [3];
    logic [2:0]  want [3];
    cmds[0] = 32'h0122_0300; halt[0] = 1'b1; want[0] = 3'd2;
    cmds[1] = 32'h0032_0300; halt[1] = 1'b1; want[1] = 3'd2;
    cmds[2] = 32'h0022_0300; halt[2] = 1'b0; want[2] = 3'd4;
    for (int i = 0; i < 3; i++) begin
      core_halted = halt[i];
      issue(cmds[i]);
      checks++;
      if ({cmderr, reg_req, busy} !== {want[i], 2'b00}) begin
        errors++;
        $display("FAIL err%0d: cmderr=%0d req=%0b busy=%0b, required %0d 0 0", i, cmderr, reg_req, busy, want[i]);
      end
      core_halted = 1'b1;
      issue(32'h0022_0301);
      checks++;
      if ({cmderr, reg_req, busy} !== {want[i], 2'b00}) begin
        errors++;
        $display("FAIL err%0d_locked: cmderr=%0d req=%0b busy=%0b, required %0d 0 0", i, cmderr, reg_req, busy, want[i]);
      end
      clear_err();
      checks++;
      if (cmderr !== 3'd0) begin
        errors++;
        $display("FAIL err%0d_clear: cmderr=%0d, required 0", i, cmderr);
      end
    end
  endtask

  task automatic test_busy();
    core_halted = 1'b1;
    issue(32'h0022_0400);
    issue(32'h0023_0500);
    checks++;
    if ({cmderr, regno, wr1_rd0, reg_req} !== {3'd1, 16'h0400, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL busy_err: cmderr=%0d regno=%h wr=%0b req=%0b, required 1 0400 0 1", cmderr, regno, wr1_rd0, reg_req);
    end
    reg_ack = 1'b1; reg_rdata = 32'hCAFE_0001;
    tick();
    reg_ack = 1'b0;
    checks++;
    if ({data0_we, data0_wdata, cmderr} !== {1'b1, 32'hCAFE_0001, 3'd1}) begin
      errors++;
      $display("FAIL busy_done: we=%0b data=%h cmderr=%0d, required 1 cafe0001 1", data0_we, data0_wdata, cmderr);
    end
    tick();
    clear_err();
  endtask

  task automatic test_timeout();
    int cyc;
    core_halted = 1'b1;
    issue(32'h0022_0010);
    cyc = 0;
    while (reg_req === 1'b1 && cyc < 20) begin
      cyc++;
      tick();
    end
    checks++;
    if (cyc != T || cmderr !== 3'd3 || data0_we !== 1'b0) begin
      errors++;
      $display("FAIL timeout: req cycles=%0d cmderr=%0d we=%0b, required %0d 3 0", cyc, cmderr, data0_we, T);
    end
    tick();
    clear_err();
    issue(32'h0022_0011);
    reg_ack = 1'b1; reg_err = 1'b1;
    tick();
    reg_ack = 1'b0; reg_err = 1'b0;
    checks++;
    if ({cmderr, data0_we, reg_req} !== {3'd3, 2'b00}) begin
      errors++;
      $display("FAIL ack_err: cmderr=%0d we=%0b req=%0b, required 3 0 0", cmderr, data0_we, reg_req);
    end
    tick();
    clear_err();
  endtask

  task automatic test_reset_mid();
    core_halted = 1'b1;
    data0 = 32'h0BAD_F00D;
    issue(32'h0023_0777);
    tick();
    sys_rstn = 1'b0;
    #1;
    checks++;
    if ({reg_req, busy, data0_we, cmderr, wr1_rd0, regno, write_data, data0_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mid: req=%0b busy=%0b we=%0b cmderr=%0d regno=%h wd=%h, all required 0",
               reg_req, busy, data0_we, cmderr, regno, write_data);
    end
    tick();
    sys_rstn = 1'b1;
    tick();
    issue(32'h0022_0123);
    tick();
    reg_ack = 1'b1; reg_rdata = 32'h7777_1111;
    tick();
    reg_ack = 1'b0;
    checks++;
    if ({data0_we, data0_wdata, cmderr} !== {1'b1, 32'h7777_1111, 3'd0}) begin
      errors++;
      $display("FAIL reset_recover: we=%0b data=%h cmderr=%0d, required 1 77771111 0", data0_we, data0_wdata, cmderr);
    end
    tick();
  endtask

  // Random commands: the model predicts the error code, whether an access
  // starts, how long reg_req stays up and what the completion reports.
  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      logic [31:0] c, d, r;
      logic        halted, e;
      logic [2:0]  werr, fin_err;
      int          lat, req_cyc;
      logic        exp_we;
      c = {($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'd0,
           1'b0,
           ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd2,
           1'b0,
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 5) != 0),
           1'($urandom_range(0, 1)),
           16'($urandom)};
      halted = ($urandom_range(0, 5) != 0);
      d = $urandom; r = $urandom;
      e = ($urandom_range(0, 4) == 0);
      lat = $urandom_range(0, T + 1);
      werr = ref_err(c, halted);
      core_halted = halted; data0 = d;
      issue(c);
      if (werr != 3'd0 || !c[17]) begin
        checks++;
        if ({cmderr, reg_req, busy} !== {werr, 2'b00}) begin
          errors++;
          $display("FAIL rnd%0d_nostart: cmd=%h cmderr=%0d req=%0b busy=%0b, required %0d 0 0",
                   it, c, cmderr, reg_req, busy, werr);
        end
        if (werr != 3'd0) clear_err();
      end else begin
        req_cyc = (lat < T) ? lat + 1 : T;
        exp_we  = (lat < T) && !e && !c[16];
        fin_err = (lat < T && !e) ? 3'd0 : 3'd3;
        for (int k = 0; k < req_cyc; k++) begin
          checks++;
          if ({reg_req, busy, wr1_rd0, regno, write_data} !== {2'b11, c[16], c[15:0], d}) begin
            errors++;
            $display("FAIL rnd%0d_req%0d: req=%0b busy=%0b wr=%0b regno=%h wd=%h, required 1 1 %0b %h %h",
                     it, k, reg_req, busy, wr1_rd0, regno, write_data, c[16], c[15:0], d);
          end
          if (k == lat) begin reg_ack = 1'b1; reg_err = e; reg_rdata = r; end
          tick();
          reg_ack = 1'b0; reg_err = 1'b0;
        end
        checks++;
        if ({reg_req, busy, data0_we, cmderr} !== {2'b01, exp_we, fin_err} ||
            (exp_we && data0_wdata !== r)) begin
          errors++;
          $display("FAIL rnd%0d_done: req=%0b busy=%0b we=%0b cmderr=%0d data=%h, required 0 1 %0b %0d %h",
                   it, reg_req, busy, data0_we, cmderr, data0_wdata, exp_we, fin_err, r);
        end
        tick();
        checks++;
        if ({busy, data0_we} !== 2'b00) begin
          errors++;
          $display("FAIL rnd%0d_idle: busy=%0b we=%0b, required 0 0", it, busy, data0_we);
        end
        if (fin_err != 3'd0) clear_err();
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_errors();
    test_busy();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
